pc_sequencer: RTL and testbench

- Parametrised next-generation program counter for the cpu_project control path.
- Replaces the fixed 8-bit counter with a configurable-width PC.
- Provides a priority-resolved next-PC selection: hold, increment, absolute load, signed relative branch, call and return.
- Includes a hardware return-address stack of configurable depth with sticky overflow/underflow error flags; feeds instruction fetch directly.

---
 rtl/pc_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter with prioritised next-PC selection and a hardware return-address stack.
// Stack overflow/underflow are reported through sticky flags; faulting calls/returns degrade.
module pc_sequencer #(
    parameter int unsigned     PC_W        = 8,
    parameter int unsigned     STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic                               i_clk,
    input  logic                               i_rstn,
    input  logic                               i_stall,
    input  logic                               i_pi,
    input  logic                               i_pl,
    input  logic                               i_ms,
    input  logic                               i_call,
    input  logic                               i_ret,
    input  logic                               i_clr_err,
    input  logic [PC_W-1:0]                    i_target,
    output logic [PC_W-1:0]                    o_pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   o_sp,
    output logic                               o_full,
    output logic                               o_empty,
    output logic                               o_ovf,
    output logic                               o_unf,
    output logic                               o_redirect
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            redirect_q, redirect_d;

    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic [PC_W-1:0] stack_top;
    logic [PC_W-1:0] pc_inc;
    logic            push;
    logic            full;
    logic            empty;

    assign full   = (sp_q == SP_W'(STACK_DEPTH));
    assign empty  = (sp_q == '0);
    assign pc_inc = pc_q + PC_W'(1);

    // Entry sp-1 is the top; entries at or above sp are never selected.
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                stack_top = stack_q[i];
            end
        end
    end

    always_comb begin
        pc_d       = pc_q;
        sp_d       = sp_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        redirect_d = redirect_q;
        push       = 1'b0;

        if (!i_stall) begin
            redirect_d = 1'b0;
            if (i_clr_err) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end

            if (i_ret) begin
                if (!empty) begin
                    pc_d       = stack_top;
                    sp_d       = sp_q - SP_W'(1);
                    redirect_d = 1'b1;
                end else begin
                    unf_d = 1'b1;
                end
            end else if (i_call) begin
                if (!full) begin
                    push       = 1'b1;
                    sp_d       = sp_q + SP_W'(1);
                    pc_d       = i_target;
                    redirect_d = 1'b1;
                end else begin
                    // Call with no room to push falls through as a plain increment.
                    pc_d  = pc_inc;
                    ovf_d = 1'b1;
                end
            end else if (i_pl) begin
                pc_d       = i_target;
                redirect_d = 1'b1;
            end else if (i_ms) begin
                // Same-width add is the sign-extended add truncated to PC_W.
                pc_d       = pc_q + i_target;
                redirect_d = 1'b1;
            end else if (i_pi) begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pc_q       <= RESET_PC;
            sp_q       <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            redirect_q <= redirect_d;
        end
    end

    // Stack contents need no reset; only sp qualifies them.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            if (push && (sp_q == SP_W'(i))) begin
                stack_q[i] <= pc_inc;
            end
        end
    end

    assign o_pc       = pc_q;
    assign o_sp       = sp_q;
    assign o_full     = full;
    assign o_empty    = empty;
    assign o_ovf      = ovf_q;
    assign o_unf      = unf_q;
    assign o_redirect = redirect_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer with a queue of expected post-edge states.
module tb_pc_sequencer;

    localparam logic [6:0] R_NONE  = 7'b0000000;
    localparam logic [6:0] R_STALL = 7'b1000000;
    localparam logic [6:0] R_RET   = 7'b0100000;
    localparam logic [6:0] R_CALL  = 7'b0010000;
    localparam logic [6:0] R_PL    = 7'b0001000;
    localparam logic [6:0] R_MS    = 7'b0000100;
    localparam logic [6:0] R_PI    = 7'b0000010;
    localparam logic [6:0] R_CLR   = 7'b0000001;

    typedef struct {
        logic [6:0] req;
        logic [7:0] tgt;
        logic [7:0] pc;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
        logic       rd;
    } vec_t;

    logic       clk;
    logic       rstn;
    logic       stall, pi, pl, ms, call, ret, clr;
    logic [7:0] target;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       full, empty, ovf, unf, redirect;

    int n_checks;
    int n_pass;

    vec_t vecs[$];
    vec_t sb[$];

    pc_sequencer #(
        .PC_W       (8),
        .STACK_DEPTH(4),
        .RESET_PC   (8'h00)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_stall   (stall),
        .i_pi      (pi),
        .i_pl      (pl),
        .i_ms      (ms),
        .i_call    (call),
        .i_ret     (ret),
        .i_clr_err (clr),
        .i_target  (target),
        .o_pc      (pc),
        .o_sp      (sp),
        .o_full    (full),
        .o_empty   (empty),
        .o_ovf     (ovf),
        .o_unf     (unf),
        .o_redirect(redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] req, input logic [7:0] tgt,
                                input logic [7:0] epc, input logic [2:0] esp,
                                input logic eovf, input logic eunf, input logic erd);
        vec_t v;
        v.req = req;
        v.tgt = tgt;
        v.pc  = epc;
        v.sp  = esp;
        v.ovf = eovf;
        v.unf = eunf;
        v.rd  = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] req, input logic [7:0] tgt);
        {stall, ret, call, pl, ms, pi, clr} = req;
        target = tgt;
    endtask

    task automatic check_state(input string tag, input vec_t e);
        check({tag, " pc"}, 32'(pc), 32'(e.pc));
        check({tag, " sp"}, 32'(sp), 32'(e.sp));
        check({tag, " full"}, 32'(full), 32'(e.sp == 3'd4));
        check({tag, " empty"}, 32'(empty), 32'(e.sp == 3'd0));
        check({tag, " ovf"}, 32'(ovf), 32'(e.ovf));
        check({tag, " unf"}, 32'(unf), 32'(e.unf));
        check({tag, " redirect"}, 32'(redirect), 32'(e.rd));
    endtask

    initial begin
        vec_t e;
        n_checks = 0;
        n_pass   = 0;
        rstn     = 1'b0;
        drive(R_NONE, 8'h00);

        // Increment and wrap
        vecs.push_back(mk(R_PI,   8'h00, 8'h01, 3'd0, 0, 0, 0));
        vecs.push_back(mk(R_PI,   8'h00, 8'h02, 3'd0, 0, 0, 0));
        vecs.push_back(mk(R_PI,   8'h00, 8'h03, 3'd0, 0, 0, 0));
        vecs.push_back(mk(R_PL,   8'hFF, 8'hFF, 3'd0, 0, 0, 1));
        vecs.push_back(mk(R_PI,   8'h00, 8'h00, 3'd0, 0, 0, 0));
        // Relative branches in both directions
        vecs.push_back(mk(R_PL,   8'h10, 8'h10, 3'd0, 0, 0, 1));
        vecs.push_back(mk(R_MS,   8'hFC, 8'h0C, 3'd0, 0, 0, 1));
        vecs.push_back(mk(R_NONE, 8'h00, 8'h0C, 3'd0, 0, 0, 0));
        vecs.push_back(mk(R_PL,   8'hFE, 8'hFE, 3'd0, 0, 0, 1));
        vecs.push_back(mk(R_MS,   8'h05, 8'h03, 3'd0, 0, 0, 1));
        // Single call/return
        vecs.push_back(mk(R_PL,   8'h20, 8'h20, 3'd0, 0, 0, 1));
        vecs.push_back(mk(R_CALL, 8'h80, 8'h80, 3'd1, 0, 0, 1));
        vecs.push_back(mk(R_RET,  8'h00, 8'h21, 3'd0, 0, 0, 1));
        // Fill, overflow, LIFO drain, underflow
        vecs.push_back(mk(R_PL,   8'h00, 8'h00, 3'd0, 0, 0, 1));
        vecs.push_back(mk(R_CALL, 8'h40, 8'h40, 3'd1, 0, 0, 1));
        vecs.push_back(mk(R_CALL, 8'h40, 8'h40, 3'd2, 0, 0, 1));
        vecs.push_back(mk(R_CALL, 8'h40, 8'h40, 3'd3, 0, 0, 1));
        vecs.push_back(mk(R_CALL, 8'h40, 8'h40, 3'd4, 0, 0, 1));
        vecs.push_back(mk(R_CALL, 8'h40, 8'h41, 3'd4, 1, 0, 0));
        vecs.push_back(mk(R_RET,  8'h00, 8'h41, 3'd3, 1, 0, 1));
        vecs.push_back(mk(R_RET,  8'h00, 8'h41, 3'd2, 1, 0, 1));
        vecs.push_back(mk(R_RET,  8'h00, 8'h41, 3'd1, 1, 0, 1));
        vecs.push_back(mk(R_RET,  8'h00, 8'h01, 3'd0, 1, 0, 1));
        vecs.push_back(mk(R_RET,  8'h00, 8'h01, 3'd0, 1, 1, 0));
        vecs.push_back(mk(R_CLR,  8'h00, 8'h01, 3'd0, 0, 0, 0));
        vecs.push_back(mk(R_CLR | R_RET, 8'h00, 8'h01, 3'd0, 0, 1, 0));
        // Stall freezes everything, including a pending clear
        vecs.push_back(mk(R_PL,   8'h50, 8'h50, 3'd0, 0, 1, 1));
        vecs.push_back(mk(R_STALL | R_PI | R_CALL | R_RET | R_CLR, 8'h99, 8'h50, 3'd0, 0, 1, 1));
        vecs.push_back(mk(R_STALL | R_PI | R_CALL | R_RET | R_CLR, 8'h99, 8'h50, 3'd0, 0, 1, 1));
        // Priority: call over load/increment, then return over call
        vecs.push_back(mk(R_CALL | R_PL | R_PI, 8'h33, 8'h33, 3'd1, 0, 1, 1));
        vecs.push_back(mk(R_CALL | R_RET, 8'h77, 8'h51, 3'd0, 0, 1, 1));
        vecs.push_back(mk(R_CLR,  8'h00, 8'h51, 3'd0, 0, 0, 0));
        vecs.push_back(mk(R_CALL, 8'h60, 8'h60, 3'd1, 0, 0, 1));
        vecs.push_back(mk(R_PI,   8'h00, 8'h61, 3'd1, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        e = mk(R_NONE, 8'h00, 8'h00, 3'd0, 0, 0, 0);
        check_state("reset", e);

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].tgt);
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check("scoreboard empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check_state($sformatf("vec%0d", i), e);
            end
        end

        // Asynchronous reset mid-cycle with a call pending and stack non-empty
        drive(R_CALL, 8'hAA);
        #2 rstn = 1'b0;
        #1;
        e = mk(R_NONE, 8'h00, 8'h00, 3'd0, 0, 0, 0);
        check_state("async_rst", e);
        @(posedge clk);
        #1;
        check_state("rst_held", e);
        rstn = 1'b1;
        drive(R_PI, 8'h00);
        @(posedge clk);
        #1;
        e = mk(R_NONE, 8'h00, 8'h01, 3'd0, 0, 0, 0);
        check_state("post_rst", e);
        drive(R_NONE, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
